// File: rtl/intro_animator_pkg.sv
// Shared types and default constants for the title-screen intro animation.
// Phase encoding is what the draw path and game FSM see on `phase`.
package intro_animator_pkg;

    typedef enum logic [2:0] {
        CLIMB = 3'd0,
        RISE  = 3'd1,
        FALL  = 3'd2,
        LAND  = 3'd3,
        DONE  = 3'd4
    } phase_e;

    localparam int PRESC_W = 16;

    localparam int DEF_X_START     = 484;
    localparam int DEF_Y_START     = 672;
    localparam int DEF_Y_TOP       = 175;
    localparam int DEF_JUMP_HEIGHT = 20;
    localparam int DEF_NUM_JUMPS   = 4;
    localparam int DEF_STEP_DIV    = 4;
    localparam int DEF_JUMP_DIV    = 2;
    localparam int DEF_RUNG_PITCH  = 32;
    localparam int DEF_RUNG_Y_MAX  = 576;
    localparam int DEF_MAX_RUNGS   = 15;

endpackage

// File: rtl/intro_animator_if.sv
// Control/sprite bundle between the game FSM (master) and the animator (slave).
// The mask width must match the animator's NUM_JUMPS.
interface intro_animator_if #(
    parameter int NUM_JUMPS = 4
);
    logic                 start;
    logic                 skip;
    logic                 restart;
    logic                 active;
    logic                 done;
    logic [11:0]          xpos;
    logic [11:0]          ypos;
    logic [3:0]           rung_cnt;
    logic [NUM_JUMPS-1:0] land_mask;
    logic [2:0]           phase;

    modport master (
        output start, skip, restart,
        input  active, done, xpos, ypos,
        input  rung_cnt, land_mask, phase
    );

    modport slave (
        input  start, skip, restart,
        output active, done, xpos, ypos,
        output rung_cnt, land_mask, phase
    );
endinterface

// File: rtl/intro_animator_tick_prescaler.sv
// Free-running divider: tick on the div-1 count, restart from 0 on clear.
// Keeps counting regardless of whether the tick is consumed.
module tick_prescaler
    import intro_animator_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PRESC_W-1:0] div,
    input  logic               clear,
    output logic               tick
);
    logic [PRESC_W-1:0] cnt;

    assign tick = (cnt == div - PRESC_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESC_W'(1);
        end
    end
endmodule

// File: rtl/intro_animator.sv
// Intro sprite animator: ladder climb, NUM_JUMPS hop cycles, then park.
// Supports skip-to-end and restart from the parked pose.
module intro_animator
    import intro_animator_pkg::*;
#(
    parameter int X_START     = DEF_X_START,
    parameter int Y_START     = DEF_Y_START,
    parameter int Y_TOP       = DEF_Y_TOP,
    parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
    parameter int NUM_JUMPS   = DEF_NUM_JUMPS,
    parameter int STEP_DIV    = DEF_STEP_DIV,
    parameter int JUMP_DIV    = DEF_JUMP_DIV,
    parameter int RUNG_PITCH  = DEF_RUNG_PITCH,
    parameter int RUNG_Y_MAX  = DEF_RUNG_Y_MAX,
    parameter int MAX_RUNGS   = DEF_MAX_RUNGS
) (
    input  logic            clk,
    input  logic            rst_n,
    intro_animator_if.slave bus
);
    localparam logic [11:0] Y_ST   = 12'(Y_START);
    localparam logic [11:0] Y_TP   = 12'(Y_TOP);
    localparam logic [12:0] Y_TP13 = 13'(Y_TOP);
    localparam logic [11:0] APEX   = 12'(Y_TOP - JUMP_HEIGHT);
    localparam logic [11:0] R_MAX  = 12'(RUNG_Y_MAX);
    localparam logic [11:0] R_MSK  = 12'(RUNG_PITCH - 1);
    localparam logic [3:0]  R_SAT  = 4'(MAX_RUNGS);
    localparam logic [3:0]  NJ     = 4'(NUM_JUMPS);

    phase_e               state, st_n;
    logic [11:0]          ypos, y_n;
    logic [11:0]          vel, vel_n, v_inc;
    logic [3:0]           jidx, jidx_n;
    logic [3:0]           rung, rung_n;
    logic [NUM_JUMPS-1:0] mask, mask_n;
    logic                 done_r, done_n;
    logic                 act_r, act_n;
    logic                 tick, clear;
    logic [PRESC_W-1:0]   div;

    assign div   = (state == CLIMB) ? PRESC_W'(STEP_DIV)
                                    : PRESC_W'(JUMP_DIV);
    assign clear = (st_n != state);
    assign v_inc = vel + 12'd1;

    tick_prescaler u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (div),
        .clear (clear),
        .tick  (tick)
    );

    always_comb begin
        st_n   = state;
        y_n    = ypos;
        vel_n  = vel;
        jidx_n = jidx;
        rung_n = rung;
        mask_n = mask;
        unique case (state)
            CLIMB: begin
                if (ypos <= Y_TP) begin
                    st_n = RISE;
                end else if (tick && bus.start) begin
                    y_n = ypos - 12'd1;
                    if (ypos <= R_MAX && (ypos & R_MSK) == 12'd0
                        && rung != R_SAT) begin
                        rung_n = rung + 4'd1;
                    end
                end
            end
            RISE: begin
                if (ypos <= APEX) begin
                    st_n = FALL;
                end else if (tick) begin
                    // Compare against apex+v so the subtraction can't wrap
                    if (ypos <= APEX + v_inc) begin
                        y_n   = APEX;
                        vel_n = '0;
                    end else begin
                        y_n   = ypos - v_inc;
                        vel_n = v_inc;
                    end
                end
            end
            FALL: begin
                if (ypos >= Y_TP) begin
                    st_n = LAND;
                end else if (tick) begin
                    vel_n = v_inc;
                    if ({1'b0, ypos} + {1'b0, v_inc} >= Y_TP13) begin
                        y_n    = Y_TP;
                        jidx_n = jidx + 4'd1;
                        for (int i = 0; i < NUM_JUMPS; i++) begin
                            if (jidx == 4'(i)) mask_n[i] = 1'b1;
                        end
                    end else begin
                        y_n = ypos + v_inc;
                    end
                end
            end
            LAND: begin
                vel_n = '0;
                st_n  = (jidx < NJ) ? RISE : DONE;
            end
            DONE: begin
                if (bus.restart) begin
                    st_n   = CLIMB;
                    y_n    = Y_ST;
                    vel_n  = '0;
                    jidx_n = '0;
                    rung_n = '0;
                    mask_n = '0;
                end
            end
            default: st_n = CLIMB;
        endcase
        // Skip overrides whatever the current phase computed
        if (bus.skip && state != DONE) begin
            st_n   = DONE;
            y_n    = Y_TP;
            mask_n = '1;
            rung_n = R_SAT;
        end
        done_n = (st_n == DONE) && (state != DONE);
        act_n  = (st_n != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLIMB;
            ypos   <= Y_ST;
            vel    <= '0;
            jidx   <= '0;
            rung   <= '0;
            mask   <= '0;
            done_r <= 1'b0;
            act_r  <= 1'b1;
        end else begin
            state  <= st_n;
            ypos   <= y_n;
            vel    <= vel_n;
            jidx   <= jidx_n;
            rung   <= rung_n;
            mask   <= mask_n;
            done_r <= done_n;
            act_r  <= act_n;
        end
    end

    assign bus.xpos      = 12'(X_START);
    assign bus.ypos      = ypos;
    assign bus.rung_cnt  = rung;
    assign bus.land_mask = mask;
    assign bus.done      = done_r;
    assign bus.active    = act_r;
    assign bus.phase     = state;
endmodule

// File: tb/tb_intro_animator.sv
// Directed bench for intro_animator with queue-based expected values.
// Covers climb timing, jumps, start gaps, skip, restart and async reset.
module tb_intro_animator;
    import intro_animator_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intro_animator_if #(.NUM_JUMPS(4)) bus();

    intro_animator #(
        .X_START     (484),
        .Y_START     (200),
        .Y_TOP       (175),
        .JUMP_HEIGHT (20),
        .NUM_JUMPS   (4),
        .STEP_DIV    (4),
        .JUMP_DIV    (2),
        .RUNG_PITCH  (8),
        .RUNG_Y_MAX  (192),
        .MAX_RUNGS   (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int cycles;
    logic track_climb = 1'b0;
    logic track_jump = 1'b0;
    logic [11:0] exp_y[$];
    logic [11:0] exp_apex[$];
    logic [3:0]  exp_mask[$];
    logic [11:0] prev_y = 12'd200;
    logic [2:0]  prev_ph = 3'd0;
    logic [3:0]  prev_mask = 4'd0;
    logic [11:0] y0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_climb();
        exp_y.delete();
        for (int y = 199; y >= 175; y--) exp_y.push_back(12'(y));
    endtask

    task automatic cyc();
        logic [11:0] e;
        logic [3:0]  m;
        @(posedge clk);
        #1;
        if (track_climb && bus.ypos != prev_y) begin
            if (exp_y.size() == 0) begin
                chk("climb_extra", 32'(bus.ypos), 32'(prev_y));
            end else begin
                e = exp_y.pop_front();
                chk("climb_y", 32'(bus.ypos), 32'(e));
            end
        end
        if (track_jump && bus.phase == 3'(FALL) && prev_ph == 3'(RISE)) begin
            if (exp_apex.size() == 0) begin
                chk("apex_extra", 1, 0);
            end else begin
                e = exp_apex.pop_front();
                chk("apex", 32'(bus.ypos), 32'(e));
            end
        end
        if (track_jump && bus.land_mask != prev_mask) begin
            if (exp_mask.size() == 0) begin
                chk("mask_extra", 32'(bus.land_mask), 32'(prev_mask));
            end else begin
                m = exp_mask.pop_front();
                chk("land_mask", 32'(bus.land_mask), 32'(m));
            end
        end
        if (bus.done) begin
            done_cnt++;
            chk("done_entry",
                32'(bus.phase == 3'(DONE) && prev_ph != 3'(DONE)), 1);
        end
        prev_y    = bus.ypos;
        prev_ph   = bus.phase;
        prev_mask = bus.land_mask;
    endtask

    task automatic run_climb();
        cycles = 0;
        while (bus.ypos != 12'd175 && cycles < 400) begin
            if (cycles == 50) bus.restart = 1'b1;
            else bus.restart = 1'b0;
            cyc();
            cycles++;
            if (cycles == 51) chk("restart_ign", 32'(bus.phase), 32'(CLIMB));
        end
        bus.restart = 1'b0;
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        cyc();
        bus.restart = 1'b0;
    endtask

    initial begin
        bus.start = 1'b1;
        bus.skip = 1'b0;
        bus.restart = 1'b0;
        #12;
        chk("rst_xpos", 32'(bus.xpos), 484);
        chk("rst_ypos", 32'(bus.ypos), 200);
        chk("rst_active", 32'(bus.active), 1);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_rung", 32'(bus.rung_cnt), 0);
        chk("rst_mask", 32'(bus.land_mask), 0);
        chk("rst_phase", 32'(bus.phase), 32'(CLIMB));
        @(negedge clk);
        rst_n = 1'b1;

        push_climb();
        track_climb = 1'b1;
        run_climb();
        track_climb = 1'b0;
        chk("climb_cycles", cycles, 100);
        chk("climb_left", exp_y.size(), 0);
        chk("climb_rungs", 32'(bus.rung_cnt), 3);
        cyc();
        chk("to_rise", 32'(bus.phase), 32'(RISE));

        for (int i = 0; i < 4; i++) exp_apex.push_back(12'd155);
        exp_mask.push_back(4'b0001);
        exp_mask.push_back(4'b0011);
        exp_mask.push_back(4'b0111);
        exp_mask.push_back(4'b1111);
        done_cnt = 0;
        track_jump = 1'b1;
        cycles = 0;
        while (bus.phase != 3'(DONE) && cycles < 2000) begin
            cyc();
            cycles++;
        end
        chk("run_timeout", 32'(cycles < 2000), 1);
        repeat (5) cyc();
        track_jump = 1'b0;
        chk("run_apex_left", exp_apex.size(), 0);
        chk("run_mask_left", exp_mask.size(), 0);
        chk("run_done_cnt", done_cnt, 1);
        chk("run_active", 32'(bus.active), 0);
        chk("run_ypos", 32'(bus.ypos), 175);
        chk("run_mask", 32'(bus.land_mask), 15);
        chk("run_phase", 32'(bus.phase), 32'(DONE));
        bus.skip = 1'b1;
        cyc();
        bus.skip = 1'b0;
        cyc();
        chk("skip_in_done", done_cnt, 1);

        pulse_restart();
        chk("rs_ypos", 32'(bus.ypos), 200);
        chk("rs_mask", 32'(bus.land_mask), 0);
        chk("rs_rung", 32'(bus.rung_cnt), 0);
        chk("rs_active", 32'(bus.active), 1);
        chk("rs_phase", 32'(bus.phase), 32'(CLIMB));
        push_climb();
        track_climb = 1'b1;
        run_climb();
        track_climb = 1'b0;
        chk("rs_cycles", cycles, 100);
        chk("rs_left", exp_y.size(), 0);
        chk("rs_rungs", 32'(bus.rung_cnt), 3);

        cycles = 0;
        while (!(bus.phase == 3'(FALL) && bus.land_mask == 4'b0001)
               && cycles < 500) begin
            cyc();
            cycles++;
        end
        chk("fall2_timeout", 32'(cycles < 500), 1);
        done_cnt = 0;
        bus.skip = 1'b1;
        cyc();
        bus.skip = 1'b0;
        chk("skip_phase", 32'(bus.phase), 32'(DONE));
        chk("skip_mask", 32'(bus.land_mask), 15);
        chk("skip_rung", 32'(bus.rung_cnt), 15);
        chk("skip_ypos", 32'(bus.ypos), 175);
        chk("skip_done", 32'(bus.done), 1);
        cyc();
        chk("skip_done_off", 32'(bus.done), 0);
        chk("skip_done_cnt", done_cnt, 1);

        pulse_restart();
        push_climb();
        track_climb = 1'b1;
        repeat (30) cyc();
        y0 = bus.ypos;
        chk("gap_pre_y", 32'(y0), 193);
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("gap_hold", 32'(bus.ypos), 32'(y0));
        end
        bus.start = 1'b1;
        cycles = 0;
        while (bus.ypos != 12'd175 && cycles < 400) begin
            cyc();
            cycles++;
        end
        track_climb = 1'b0;
        chk("gap_cycles", cycles, 70);
        chk("gap_left", exp_y.size(), 0);
        chk("gap_rungs", 32'(bus.rung_cnt), 3);

        cyc();
        repeat (3) cyc();
        chk("pre_rst_phase", 32'(bus.phase), 32'(RISE));
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_ypos", 32'(bus.ypos), 200);
        chk("ar_phase", 32'(bus.phase), 32'(CLIMB));
        chk("ar_active", 32'(bus.active), 1);
        chk("ar_done", 32'(bus.done), 0);
        chk("ar_rung", 32'(bus.rung_cnt), 0);
        chk("ar_mask", 32'(bus.land_mask), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cyc();
        chk("ar_phase2", 32'(bus.phase), 32'(CLIMB));
        chk("ar_step1", 32'(bus.ypos), 199);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
